sqrt: RTL and testbench

- Iterative IEEE-754 single-precision square-root unit.
- Accepts one 32-bit operand on a start pulse and computes the correctly rounded root (round-to-nearest-even) with a restoring digit-by-digit algorithm.
- Returns the result after a fixed latency, signalled by a one-cycle done pulse.
- Sits beside the FP add/mul units as a multi-cycle functional unit.

---
 rtl/sqrt.sv | 186 ++++++++++++++++++
 tb/tb_sqrt.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt.sv
// Iterative IEEE-754 single-precision square root, restoring digit-by-digit, RNE rounding.
// Define SQRT_DENORM_EN to normalize denormal operands instead of flushing them to zero.
module sqrt #(
    parameter int ITER = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND} state_t;

    state_t             r_state, w_next;
    logic [31:0]        r_a;
    logic [4:0]         r_cnt;
    logic               r_special;
    logic [31:0]        r_spec_val;
    logic [7:0]         r_exp;
    logic [49:0]        r_rad;
    logic [26:0]        r_rem;
    logic [24:0]        r_root;
    logic [31:0]        r_result;
    logic               r_done;

    logic               w_load, w_unpack, w_iter, w_round;

    // ---------------- operand decode ----------------
    logic               w_s;
    logic [7:0]         w_e;
    logic [22:0]        w_f;
    logic [23:0]        w_m24;
    logic [24:0]        w_m25;
    logic signed [9:0]  w_exp_unb, w_exp_adj, w_exp_half;
    logic               w_odd;
    logic [7:0]         w_rexp;
    logic               w_special;
    logic [31:0]        w_spec_val;

    assign w_s = r_a[31];
    assign w_e = r_a[30:23];
    assign w_f = r_a[22:0];

`ifdef SQRT_DENORM_EN
    function automatic logic [4:0] lzc23(input logic [22:0] v);
        lzc23 = 5'd23;
        for (int i = 0; i < 23; i++)
            if (v[i]) lzc23 = 5'(22 - i);
    endfunction

    logic [4:0] w_lz;
    assign w_lz = lzc23(w_f);
`endif

    always_comb begin
        w_m24     = {1'b1, w_f};
        w_exp_unb = $signed({2'b00, w_e}) - 10'sd127;
`ifdef SQRT_DENORM_EN
        if (w_e == 8'd0) begin
            w_m24     = {1'b0, w_f} << (w_lz + 5'd1);
            w_exp_unb = -10'sd127 - $signed({5'd0, w_lz});
        end
`endif
        // odd exponent: fold one factor of 2 into the radicand
        w_odd      = w_exp_unb[0];
        w_m25      = w_odd ? {w_m24, 1'b0} : {1'b0, w_m24};
        w_exp_adj  = w_odd ? w_exp_unb - 10'sd1 : w_exp_unb;
        w_exp_half = w_exp_adj >>> 1;
        w_rexp     = 8'(w_exp_half + 10'sd127);
    end

    always_comb begin
        w_special  = 1'b1;
        w_spec_val = 32'h7FC0_0000;
        if (w_e == 8'hFF && w_f != 23'd0)
            w_spec_val = 32'h7FC0_0000;
        else if (w_e == 8'd0 && w_f == 23'd0)
            w_spec_val = r_a;
`ifndef SQRT_DENORM_EN
        else if (w_e == 8'd0)
            w_spec_val = {w_s, 31'd0};
`endif
        else if (w_s)
            w_spec_val = 32'h7FC0_0000;
        else if (w_e == 8'hFF)
            w_spec_val = 32'h7F80_0000;
        else
            w_special  = 1'b0;
    end

    // ---------------- one restoring step ----------------
    logic [28:0] w_cat, w_sub, w_diff;
    logic        w_ge;

    always_comb begin
        w_cat  = {r_rem, r_rad[49:48]};
        w_sub  = {2'b00, r_root, 2'b01};
        w_diff = w_cat - w_sub;
        w_ge   = (w_cat >= w_sub);
    end

    // ---------------- rounding ----------------
    logic        w_sticky, w_up, w_carry;
    logic [24:0] w_msum;
    logic [22:0] w_frac;
    logic [7:0]  w_fexp;

    always_comb begin
        w_sticky = |r_rem;
        w_up     = r_root[0] & (w_sticky | r_root[1]);
        w_msum   = {1'b0, r_root[24:1]} + {24'd0, w_up};
        w_carry  = w_msum[24];
        w_frac   = w_carry ? w_msum[23:1] : w_msum[22:0];
        w_fexp   = r_exp + {7'd0, w_carry};
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start && !r_done) w_next = S_UNPACK;
            S_UNPACK: w_next = S_ITER;
            S_ITER:   if (r_cnt == 5'(ITER - 1)) w_next = S_ROUND;
            S_ROUND:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == S_IDLE) && start && !r_done;
        w_unpack = (r_state == S_UNPACK);
        w_iter   = (r_state == S_ITER);
        w_round  = (r_state == S_ROUND);
        busy     = (r_state != S_IDLE) || r_done;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= 32'd0;
            r_cnt      <= 5'd0;
            r_special  <= 1'b0;
            r_spec_val <= 32'd0;
            r_exp      <= 8'd0;
            r_rad      <= 50'd0;
            r_rem      <= 27'd0;
            r_root     <= 25'd0;
            r_result   <= 32'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) r_a <= a;
            if (w_unpack) begin
                r_special  <= w_special;
                r_spec_val <= w_spec_val;
                r_exp      <= w_rexp;
                r_rad      <= {w_m25, 25'd0};
                r_rem      <= 27'd0;
                r_root     <= 25'd0;
                r_cnt      <= 5'd0;
            end
            if (w_iter) begin
                r_rem  <= w_ge ? w_diff[26:0] : w_cat[26:0];
                r_root <= {r_root[23:0], w_ge};
                r_rad  <= {r_rad[47:0], 2'b00};
                r_cnt  <= r_cnt + 5'd1;
            end
            if (w_round) begin
                r_result <= r_special ? r_spec_val : {1'b0, w_fexp, w_frac};
                r_done   <= 1'b1;
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule

// File: tb/tb_sqrt.sv
// Self-checking bench for sqrt: scoreboard of expected roots, latency, busy/done and reset abort.
module tb_sqrt;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    sqrt dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] op);
        start = 1'b1;
        a     = op;
        tick();
        start = 1'b0;
    endtask

    // waits from just after the accepting edge; checks latency, result, busy in done cycle
    task automatic wait_done(input string nm);
        int          k;
        logic [31:0] exp_v;
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        n_vec++;
        if (k !== 27) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges, want 27", nm, k);
        end
        n_vec++;
        if (result !== exp_v) begin
            n_err++;
            $display("FAIL %s result: got %h, want %h", nm, result, exp_v);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_at_done: got %b, want 1", nm, busy);
        end
    endtask

    task automatic check_idle(input string nm);
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle_after_done: got busy=%b done=%b, want 0 0", nm, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        repeat (3) tick();
        n_vec++;
        if (result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_result: got %h, want 00000000", result);
        end
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got done=%b busy=%b, want 0 0", done, busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        logic [31:0] ops[15];
        logic [31:0] exps[15];
        ops[0]  = 32'h3F80_0000; exps[0]  = 32'h3F80_0000;
        ops[1]  = 32'h4080_0000; exps[1]  = 32'h4000_0000;
        ops[2]  = 32'h461C_4000; exps[2]  = 32'h42C8_0000;
        ops[3]  = 32'h0000_0000; exps[3]  = 32'h0000_0000;
        ops[4]  = 32'h8000_0000; exps[4]  = 32'h8000_0000;
        ops[5]  = 32'h7F80_0000; exps[5]  = 32'h7F80_0000;
        ops[6]  = 32'h4000_0000; exps[6]  = 32'h3FB5_04F3;
        ops[7]  = 32'h4040_0000; exps[7]  = 32'h3FDD_B3D7;
        ops[8]  = 32'hBF80_0000; exps[8]  = 32'h7FC0_0000;
        ops[9]  = 32'h7FC1_2345; exps[9]  = 32'h7FC0_0000;
        ops[10] = 32'h3E80_0000; exps[10] = 32'h3F00_0000;
        ops[11] = 32'h4110_0000; exps[11] = 32'h4040_0000;
        ops[12] = 32'hFF80_0000; exps[12] = 32'h7FC0_0000;
        ops[13] = 32'h7F7F_FFFF; exps[13] = 32'h5F7F_FFFF;
        ops[14] = 32'h0000_0001;
`ifdef SQRT_DENORM_EN
        exps[14] = 32'h1A35_04F3;
`else
        exps[14] = 32'h0000_0000;
`endif
        for (int i = 0; i < 15; i++) begin
            sb_q.push_back(exps[i]);
            issue(ops[i]);
            wait_done($sformatf("vec%0d_%h", i, ops[i]));
            check_idle($sformatf("vec%0d", i));
        end
    endtask

    task automatic test_busy_start();
        int          ndone, dedge;
        logic [31:0] got, exp_v;
        ndone = 0;
        dedge = 0;
        got   = 32'd0;
        sb_q.push_back(32'h4000_0000);
        issue(32'h4080_0000);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done) begin
                ndone++;
                dedge = k;
                got   = result;
            end
            if (k == 9) begin
                start = 1'b1;
                a     = 32'h4110_0000;
            end
            if (k == 10) start = 1'b0;
        end
        exp_v = sb_q.pop_front();
        n_vec++;
        if (ndone !== 1) begin
            n_err++;
            $display("FAIL busy_start_count: got %0d dones, want 1", ndone);
        end
        n_vec++;
        if (dedge !== 27) begin
            n_err++;
            $display("FAIL busy_start_latency: got %0d, want 27", dedge);
        end
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL busy_start_result: got %h, want %h", got, exp_v);
        end
    endtask

    task automatic test_done_start();
        sb_q.push_back(32'h3F80_0000);
        issue(32'h3F80_0000);
        wait_done("done_start_first");
        start = 1'b1;
        a     = 32'h4180_0000;
        sb_q.push_back(32'h4080_0000);
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_start_ignored: got busy=%b, want 0", busy);
        end
        tick();
        start = 1'b0;
        wait_done("done_start_second");
        check_idle("done_start_second");
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        issue(32'h4040_0000);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_busy: got %b, want 0", busy);
        end
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_done: got %b, want 0", done);
        end
        n_vec++;
        if (result !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_result: got %h, want 00000000", result);
        end
        reset = 1'b0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (done) ndone++;
        end
        n_vec++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL reset_mid_abort: got %0d dones, want 0", ndone);
        end
        sb_q.push_back(32'h42C8_0000);
        issue(32'h461C_4000);
        wait_done("reset_mid_after");
        check_idle("reset_mid_after");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        test_reset();
        test_vectors();
        test_busy_start();
        test_done_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
